// File: rtl/riscv_pkg.sv
// Shared RV32 core constants: fetch-stage defaults and canonical encodings.
package riscv_pkg;

   localparam int          PC_SIZE_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
   localparam int          FETCH_DEPTH_DEFAULT = 2;
   localparam int          INSTR_W             = 32;
   localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for both the in-flight PC queue
// and the decoded-instruction buffer of the fetch stage.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign do_push   = push & (count != CNT_W'(DEPTH));
   assign do_pop    = pop & (count != '0);
   assign head_data = mem[rd_ptr];

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// pairing with an in-flight PC queue, and stale-response dropping on redirect.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int                 PC_Size     = PC_SIZE_DEFAULT,
   parameter logic [PC_Size-1:0] RESET_PC    = PC_Size'(RESET_PC_DEFAULT),
   parameter int                 FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [PC_Size-1:0] redirect_pc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_Size-1:0] imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [31:0]        imem_rsp_data,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [PC_Size-1:0] if_pc,
   output logic [31:0]        if_instr
);

   localparam int               CNT_W     = $clog2(FETCH_DEPTH + 1);
   localparam int               BUF_W     = PC_Size + INSTR_W;
   localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FETCH_DEPTH);

   logic [PC_Size-1:0] fetch_pc;
   logic               req_valid_q;
   logic [CNT_W-1:0]   q_count;
   logic [CNT_W-1:0]   b_count;
   logic [CNT_W-1:0]   drop_cnt;
   logic [CNT_W-1:0]   q_next;
   logic [CNT_W-1:0]   b_next;
   logic [PC_Size-1:0] q_head_pc;
   logic [BUF_W-1:0]   b_head;
   logic               req_fire;
   logic               rsp_take;
   logic               rsp_keep;
   logic               if_fire;
   logic               redirect_lsb_unused;

   assign req_fire = req_valid_q & imem_req_ready;
   assign rsp_take = imem_rsp_valid & (q_count != '0);
   assign rsp_keep = rsp_take & ~redirect_valid & (drop_cnt == '0);
   assign if_fire  = if_valid & if_ready;

   assign redirect_lsb_unused = ^redirect_pc[1:0];

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = fetch_pc;
   assign if_valid       = (b_count != '0);
   assign if_pc          = b_head[BUF_W-1 -: PC_Size];
   assign if_instr       = b_head[INSTR_W-1:0];

   // Occupancy after this edge; the request credit is derived from these so it
   // never borrows from a pop happening in the same cycle.
   always_comb begin
      q_next = q_count;
      if (req_fire) q_next = q_next + CNT_W'(1);
      if (rsp_take) q_next = q_next - CNT_W'(1);
      b_next = b_count;
      if (rsp_keep) b_next = b_next + CNT_W'(1);
      if (if_fire)  b_next = b_next - CNT_W'(1);
      if (redirect_valid) b_next = '0;
   end

   // Every entry left in the PC queue after a redirect is stale, including one
   // handshaked in the redirect cycle itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         req_valid_q <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         req_valid_q <= ({1'b0, q_next} + {1'b0, b_next}) < DEPTH_LIM;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[PC_Size-1:2], 2'b00};
         end else if (req_fire) begin
            fetch_pc <= fetch_pc + PC_Size'(4);
         end
         if (redirect_valid) begin
            drop_cnt <= q_next;
         end else if (rsp_take && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
         end
      end
   end

   fetch_fifo #(
      .WIDTH (PC_Size),
      .DEPTH (FETCH_DEPTH)
   ) u_pc_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (rsp_take),
      .flush     (1'b0),
      .head_data (q_head_pc),
      .count     (q_count)
   );

   fetch_fifo #(
      .WIDTH (BUF_W),
      .DEPTH (FETCH_DEPTH)
   ) u_if_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rsp_keep),
      .push_data ({q_head_pc, imem_rsp_data}),
      .pop       (if_fire),
      .flush     (redirect_valid),
      .head_data (b_head),
      .count     (b_count)
   );

   rsp_needs_outstanding: assert property (
      @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (q_count != '0)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model tags
// in-flight fetches as stale on redirect; a second instance checks PC wrap.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   typedef struct { logic [31:0] pc; bit stale; } flight_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } slot_t;
   typedef struct { logic [31:0] addr; int due; } mem_t;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic        w_req_valid;
   logic        w_req_ready;
   logic [31:0] w_req_addr;
   logic        w_rsp_valid;
   logic [31:0] w_rsp_data;
   logic        w_if_valid;
   logic        w_if_ready;
   logic [31:0] w_if_pc;
   logic [31:0] w_if_instr;

   int          check_count = 0;
   int          error_count = 0;
   int          cycle = 0;
   int          last_due = 0;
   bit          coincide_hit = 0;

   flight_t     inflight[$];
   slot_t       buffer[$];
   mem_t        memq[$];
   logic [31:0] m_pc;

   int          w_seen = 0;
   bit          w_pend = 0;
   logic [31:0] w_pend_addr = 32'h0;
   logic [31:0] wrap_exp [3];

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   fetch_unit #(
      .RESET_PC (32'hFFFF_FFF8)
   ) dut_wrap (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (w_redirect_valid),
      .redirect_pc    (w_redirect_pc),
      .imem_req_valid (w_req_valid),
      .imem_req_ready (w_req_ready),
      .imem_req_addr  (w_req_addr),
      .imem_rsp_valid (w_rsp_valid),
      .imem_rsp_data  (w_rsp_data),
      .if_valid       (w_if_valid),
      .if_ready       (w_if_ready),
      .if_pc          (w_if_pc),
      .if_instr       (w_if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: an odd multiplier keeps every address's word distinct.
   function automatic logic [31:0] instr_of(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   // The wrap instance sees an always-ready, fixed 1-cycle memory and decoder.
   task automatic trackWrap();
      if (w_if_valid) begin
         if (w_seen < 3) begin
            checkOutput("wrap_if_pc", w_if_pc, wrap_exp[w_seen]);
            checkOutput("wrap_if_instr", w_if_instr, instr_of(wrap_exp[w_seen]));
         end
         w_seen++;
      end
      w_rsp_valid = w_pend;
      w_rsp_data  = instr_of(w_pend_addr);
      w_pend      = w_req_valid;
      w_pend_addr = w_req_addr;
   endtask

   task automatic resetDut();
      #2;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if_ready       = 1'b0;
      w_rsp_valid    = 1'b0;
      w_pend         = 1'b0;
      memq.delete();
      inflight.delete();
      buffer.delete();
      m_pc     = 32'h0;
      last_due = cycle;
      #1;
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
      checkOutput("rst_if_pc", if_pc, 32'h0);
      checkOutput("rst_if_instr", if_instr, 32'h0);
      checkOutput("rst_wrap_req_valid", 32'(w_req_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One cycle: compare outputs with the model, drive inputs, then advance the
   // model to what the next rising edge must produce.
   task automatic applyStimulus(input bit rdy, input bit ifr, input bit redir_in,
                                input logic [31:0] rpc, input int lat, input bit redir_on_coincide);
      bit      exp_rv;
      bit      exp_iv;
      bit      rsp;
      bit      redir;
      bit      fire;
      int      due;
      flight_t f;
      mem_t    m;
      @(posedge clk);
      #1;
      cycle++;
      exp_rv = (inflight.size() + buffer.size()) < DEPTH;
      exp_iv = buffer.size() != 0;
      checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) checkOutput("req_addr", imem_req_addr, m_pc);
      checkOutput("if_valid", 32'(if_valid), 32'(exp_iv));
      if (exp_iv) begin
         checkOutput("if_pc", if_pc, buffer[0].pc);
         checkOutput("if_instr", if_instr, buffer[0].instr);
      end
      trackWrap();

      rsp = (memq.size() != 0) && (memq[0].due <= cycle);
      if (rsp) begin
         m = memq.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(m.addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      redir = redir_in;
      if (redir_on_coincide && rsp && exp_rv && rdy) begin
         redir        = 1'b1;
         coincide_hit = 1'b1;
      end
      imem_req_ready = rdy;
      if_ready       = ifr;
      redirect_valid = redir;
      redirect_pc    = rpc;

      if (imem_req_valid && rdy) begin
         due = cycle + lat;
         if (due <= last_due) due = last_due + 1;
         memq.push_back('{imem_req_addr, due});
         last_due = due;
      end

      fire = exp_rv && rdy;
      if (exp_iv && ifr) void'(buffer.pop_front());
      if (rsp && inflight.size() != 0) begin
         f = inflight.pop_front();
         if (!f.stale && !redir) buffer.push_back('{f.pc, instr_of(f.pc)});
      end
      if (redir) begin
         buffer.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
      end
      if (fire) inflight.push_back('{m_pc, redir});
      if (redir) m_pc = {rpc[31:2], 2'b00};
      else if (fire) m_pc = m_pc + 32'd4;
   endtask

   task automatic randomPhase(input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 15) == 0, rpc, int'($urandom_range(1, 4)),
                       $urandom_range(0, 31) == 0);
      end
   endtask

   initial begin
      wrap_exp[0]      = 32'hFFFF_FFF8;
      wrap_exp[1]      = 32'hFFFF_FFFC;
      wrap_exp[2]      = 32'h0000_0000;
      rst_n            = 1'b1;
      redirect_valid   = 1'b0;
      redirect_pc      = 32'h0;
      imem_req_ready   = 1'b0;
      imem_rsp_valid   = 1'b0;
      imem_rsp_data    = 32'h0;
      if_ready         = 1'b0;
      w_redirect_valid = 1'b0;
      w_redirect_pc    = 32'h0;
      w_req_ready      = 1'b1;
      w_if_ready       = 1'b1;
      w_rsp_valid      = 1'b0;
      w_rsp_data       = 32'h0;
      m_pc             = 32'h0;

      resetDut();

      // Sequential fetch with an always-ready 1-cycle memory.
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      // Decode stall, then release.
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      // Slow memory builds outstanding requests, then a redirect drops them.
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 3, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100, 3, 1'b0);
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2, 1'b0);
      // Unaligned redirect target.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1, 1'b0);
      repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      // Redirect landing on a cycle with both a response and a request handshake.
      for (int i = 0; i < 40 && !coincide_hit; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0300, 1, 1'b1);
      end
      checkOutput("coincide_seen", 32'(coincide_hit), 32'd1);
      repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);

      randomPhase(1500);
      resetDut();
      randomPhase(1500);

      checkOutput("wrap_seen", 32'(w_seen >= 3), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
